// File: rtl/edge_req_gen_single.sv
// Edge request generator for one core. Sits behind the offset URAM: pairs each vertex ID
// with its {loffset, roffset}, queues the pairs, and walks each edge range one memory line
// at a time, producing address / lane mask / last-line requests.
module edge_req_gen_single #(
   parameter int V_ID_WIDTH   = 16,
   parameter int V_OFF_DWIDTH = 32,
   parameter int URAM_LATENCY = 5,
   parameter int LINE_SHIFT   = 4,
   parameter int FIFO_AWIDTH  = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [V_ID_WIDTH-1:0]            front_active_v_id,
   input  logic                             front_active_v_valid,
   input  logic [V_OFF_DWIDTH-1:0]          uram_loffset,
   input  logic [V_OFF_DWIDTH-1:0]          uram_roffset,
   input  logic                             uram_dvalid,
   input  logic                             edge_rd_full,
   output logic                             front_stall,
   output logic [V_OFF_DWIDTH-LINE_SHIFT-1:0] edge_rd_addr,
   output logic [(1<<LINE_SHIFT)-1:0]       edge_rd_mask,
   output logic [V_ID_WIDTH-1:0]            edge_rd_v_id,
   output logic                             edge_rd_last,
   output logic                             edge_rd_valid,
   output logic                             idle,
   output logic                             err_overflow
);

   localparam int EDGE_PER_LINE = 1 << LINE_SHIFT;
   localparam int LINE_W        = V_OFF_DWIDTH - LINE_SHIFT;
   localparam int FIFO_DEPTH    = 1 << FIFO_AWIDTH;
   localparam int ENTRY_W       = V_ID_WIDTH + 2 * V_OFF_DWIDTH;

   // Stall early enough that every read already in flight in the URAM still finds a slot.
   localparam logic [FIFO_AWIDTH:0] STALL_LEVEL = (FIFO_AWIDTH+1)'(FIFO_DEPTH - URAM_LATENCY - 1);
   localparam logic [FIFO_AWIDTH:0] FULL_LEVEL  = (FIFO_AWIDTH+1)'(FIFO_DEPTH);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_ISSUE = 1'b1;

   // Lane k of a line is live when its global edge index falls inside [lo, hi).
   function automatic logic [EDGE_PER_LINE-1:0] line_mask(
      input logic [LINE_W-1:0]       line,
      input logic [V_OFF_DWIDTH-1:0] lo,
      input logic [V_OFF_DWIDTH-1:0] hi
   );
      logic [EDGE_PER_LINE-1:0] m;
      logic [V_OFF_DWIDTH-1:0]  idx;
      m = '0;
      for (int k = 0; k < EDGE_PER_LINE; k++) begin
         idx  = {line, LINE_SHIFT'(k)};
         m[k] = (idx >= lo) && (idx < hi);
      end
      return m;
   endfunction

   // ---------------------------------------------------------------- ID align stage
   logic [URAM_LATENCY-1:0] pipe_vld_p0;
   logic [V_ID_WIDTH-1:0]   pipe_id_p0 [URAM_LATENCY];

   // Valid bits of the ID delay line; cleared on reset so no stale vertex survives.
   always_ff @(posedge clk) begin
      if (rst) begin
         pipe_vld_p0 <= '0;
      end else begin
         pipe_vld_p0[0] <= front_active_v_valid;
         for (int i = 1; i < URAM_LATENCY; i++) pipe_vld_p0[i] <= pipe_vld_p0[i-1];
      end
   end

   // ID payload of the delay line, matched in depth to the URAM read latency.
   always_ff @(posedge clk) begin
      pipe_id_p0[0] <= front_active_v_id;
      for (int i = 1; i < URAM_LATENCY; i++) pipe_id_p0[i] <= pipe_id_p0[i-1];
   end

   // The delayed valid must line up exactly with the URAM data valid.
   a_id_align: assert property (@(posedge clk) disable iff (rst)
                                pipe_vld_p0[URAM_LATENCY-1] == uram_dvalid);

   // ---------------------------------------------------------------- offset FIFO stage
   logic [ENTRY_W-1:0]     fifo_mem_p1 [FIFO_DEPTH];
   logic [FIFO_AWIDTH-1:0] wr_ptr, rd_ptr;
   logic [FIFO_AWIDTH:0]   fifo_count;
   logic                   fifo_full, fifo_empty, push, pop;
   logic [0:0]             state;
   logic [V_ID_WIDTH-1:0]   head_id;
   logic [V_OFF_DWIDTH-1:0] head_l, head_r;

   assign fifo_full  = (fifo_count == FULL_LEVEL);
   assign fifo_empty = (fifo_count == '0);
   assign push       = uram_dvalid && !fifo_full;
   assign pop        = (state == ST_IDLE) && !fifo_empty;
   assign {head_id, head_l, head_r} = fifo_mem_p1[rd_ptr];
   assign front_stall = (fifo_count >= STALL_LEVEL);

   // FIFO storage write; a push into a full FIFO is dropped.
   always_ff @(posedge clk) begin
      if (push) fifo_mem_p1[wr_ptr] <= {pipe_id_p0[URAM_LATENCY-1], uram_loffset, uram_roffset};
   end

   // Pointers, occupancy and the sticky overflow flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         fifo_count   <= '0;
         err_overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
         if (uram_dvalid && fifo_full) err_overflow <= 1'b1;
      end
   end

   // ---------------------------------------------------------------- line issue stage
   logic [LINE_W-1:0]       cur_line_p2, end_line_p2;
   logic [V_OFF_DWIDTH-1:0] cur_l_p2, cur_r_p2;
   logic [V_ID_WIDTH-1:0]   cur_id_p2;
   logic                    at_last;

   assign at_last = (cur_line_p2 == end_line_p2);

   // Walk state of the vertex being expanded; only meaningful while in ISSUE.
   always_ff @(posedge clk) begin
      if (pop) begin
         cur_line_p2 <= LINE_W'(head_l >> LINE_SHIFT);
         end_line_p2 <= LINE_W'((head_r - V_OFF_DWIDTH'(1)) >> LINE_SHIFT);
         cur_l_p2    <= head_l;
         cur_r_p2    <= head_r;
         cur_id_p2   <= head_id;
      end else if (state == ST_ISSUE && !edge_rd_full && !at_last) begin
         cur_line_p2 <= cur_line_p2 + 1'b1;
      end
   end

   // FSM and request outputs: one request per unblocked ISSUE cycle, ascending lines.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         edge_rd_valid <= 1'b0;
         edge_rd_addr  <= '0;
         edge_rd_mask  <= '0;
         edge_rd_v_id  <= '0;
         edge_rd_last  <= 1'b0;
      end else begin
         edge_rd_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               // Zero-degree entries are popped and discarded without leaving IDLE.
               if (pop && (head_l < head_r)) state <= ST_ISSUE;
            end
            default: begin
               if (!edge_rd_full) begin
                  edge_rd_valid <= 1'b1;
                  edge_rd_addr  <= cur_line_p2;
                  edge_rd_mask  <= line_mask(cur_line_p2, cur_l_p2, cur_r_p2);
                  edge_rd_v_id  <= cur_id_p2;
                  edge_rd_last  <= at_last;
                  if (at_last) state <= ST_IDLE;
               end
            end
         endcase
      end
   end

   assign idle = fifo_empty && !(|pipe_vld_p0) && (state == ST_IDLE) && !edge_rd_valid;

endmodule

// File: tb/tb_edge_req_gen_single.sv
// Directed bench for edge_req_gen_single with a line-expansion scoreboard and a URAM model.
module tb_edge_req_gen_single;

   localparam int VW = 8;
   localparam int OW = 16;
   localparam int LAT = 5;

   logic            clk = 1'b0;
   logic            rst;
   logic [VW-1:0]   front_id;
   logic            front_valid;
   logic [OW-1:0]   uram_l, uram_r;
   logic            uram_dvalid;
   logic            edge_rd_full;
   logic            front_stall;
   logic [OW-5:0]   edge_rd_addr;
   logic [15:0]     edge_rd_mask;
   logic [VW-1:0]   edge_rd_v_id;
   logic            edge_rd_last, edge_rd_valid, idle, err_overflow;

   edge_req_gen_single #(
      .V_ID_WIDTH(VW), .V_OFF_DWIDTH(OW), .URAM_LATENCY(LAT), .LINE_SHIFT(4), .FIFO_AWIDTH(4)
   ) dut (
      .clk(clk), .rst(rst),
      .front_active_v_id(front_id), .front_active_v_valid(front_valid),
      .uram_loffset(uram_l), .uram_roffset(uram_r), .uram_dvalid(uram_dvalid),
      .edge_rd_full(edge_rd_full), .front_stall(front_stall),
      .edge_rd_addr(edge_rd_addr), .edge_rd_mask(edge_rd_mask), .edge_rd_v_id(edge_rd_v_id),
      .edge_rd_last(edge_rd_last), .edge_rd_valid(edge_rd_valid),
      .idle(idle), .err_overflow(err_overflow)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [OW-5:0] addr;
      logic [15:0]   mask;
      logic [VW-1:0] vid;
      logic          last;
   } req_t;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   l_tab [256];
   int   r_tab [256];
   req_t exp_q [$];
   req_t obs_log [$];
   req_t got_r, exp_r;
   logic full_prev = 1'b0;
   logic ovf_watch = 1'b1;

   always @(posedge clk) cyc <= cyc + 1;

   // URAM model: fixed-latency lookup of the offset tables.
   logic          dl_v  [LAT];
   logic [VW-1:0] dl_id [LAT];
   logic [OW-1:0] dl_l  [LAT];
   logic [OW-1:0] dl_r  [LAT];
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < LAT; i++) dl_v[i] <= 1'b0;
      end else begin
         dl_v[0]  <= front_valid;
         dl_id[0] <= front_id;
         dl_l[0]  <= OW'(l_tab[front_id]);
         dl_r[0]  <= OW'(r_tab[front_id]);
         for (int i = 1; i < LAT; i++) begin
            dl_v[i] <= dl_v[i-1]; dl_id[i] <= dl_id[i-1];
            dl_l[i] <= dl_l[i-1]; dl_r[i] <= dl_r[i-1];
         end
      end
   end
   assign uram_dvalid = dl_v[LAT-1];
   assign uram_l      = dl_l[LAT-1];
   assign uram_r      = dl_r[LAT-1];

   // Model: the ordered list of line requests a vertex range must produce.
   task automatic expect_vertex(input int vid, input int l, input int r);
      req_t e;
      int   first, lastl;
      if (l < r) begin
         first = l / 16;
         lastl = (r - 1) / 16;
         for (int a = first; a <= lastl; a++) begin
            e.addr = (OW-4)'(a);
            e.vid  = VW'(vid);
            e.last = (a == lastl);
            e.mask = '0;
            for (int k = 0; k < 16; k++)
               if ((a * 16 + k) >= l && (a * 16 + k) < r) e.mask[k] = 1'b1;
            exp_q.push_back(e);
         end
      end
   endtask

   // Reset abandons everything the model still expected.
   always @(posedge clk) begin
      full_prev <= edge_rd_full;
      if (rst) exp_q.delete();
   end

   // Compare process: every request against the model, plus per-cycle protocol checks.
   always @(negedge clk) begin
      if (!rst) begin
         if (edge_rd_valid) begin
            got_r = '{addr: edge_rd_addr, mask: edge_rd_mask, vid: edge_rd_v_id, last: edge_rd_last};
            obs_log.push_back(got_r);
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_req: got addr=%0h mask=%04h vid=%0d last=%0b, required none",
                        got_r.addr, got_r.mask, got_r.vid, got_r.last);
            end else begin
               exp_r = exp_q.pop_front();
               if (got_r !== exp_r) begin
                  errors++;
                  $display("FAIL req: got addr=%0h mask=%04h vid=%0d last=%0b, required addr=%0h mask=%04h vid=%0d last=%0b",
                           got_r.addr, got_r.mask, got_r.vid, got_r.last,
                           exp_r.addr, exp_r.mask, exp_r.vid, exp_r.last);
               end
            end
            checks++;
            if (full_prev) begin
               errors++;
               $display("FAIL valid_while_full: got valid=1, required 0");
            end
         end
         if (ovf_watch) begin
            checks++;
            if (err_overflow !== 1'b0) begin
               errors++;
               $display("FAIL overflow_flag: got %0b, required 0", err_overflow);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
      end
   endtask

   task automatic send(input int vid, input int l, input int r);
      l_tab[vid] = l;
      r_tab[vid] = r;
      expect_vertex(vid, l, r);
      front_id    = VW'(vid);
      front_valid = 1'b1;
      @(posedge clk); #1;
      front_valid = 1'b0;
   endtask

   task automatic wait_valid(input string tag, output int vc);
      logic seen;
      seen = 1'b0;
      vc   = -1;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         if (edge_rd_valid) begin
            seen = 1'b1;
            vc   = cyc;
         end
      end
      chk(tag, 32'(seen), 32'd1);
   endtask

   task automatic drain(input string tag);
      logic done;
      done = 1'b0;
      for (int i = 0; i < 400 && !done; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && idle) done = 1'b1;
      end
      chk(tag, 32'(done), 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_valid"}, 32'(edge_rd_valid), 32'd0);
      chk({tag, "_addr"},  32'(edge_rd_addr),  32'd0);
      chk({tag, "_mask"},  32'(edge_rd_mask),  32'd0);
      chk({tag, "_vid"},   32'(edge_rd_v_id),  32'd0);
      chk({tag, "_last"},  32'(edge_rd_last),  32'd0);
      chk({tag, "_stall"}, 32'(front_stall),   32'd0);
      chk({tag, "_ovf"},   32'(err_overflow),  32'd0);
      chk({tag, "_idle"},  32'(idle),          32'd1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, vc, nsent, stall_at, vid;
      for (int i = 0; i < 256; i++) begin l_tab[i] = 0; r_tab[i] = 0; end
      rst = 1'b1; front_valid = 1'b0; front_id = '0; edge_rd_full = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_outputs("reset");
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (2) @(posedge clk); #1;

      // Case 1: single line, latency from front valid (pop + 2)
      obs_log.delete();
      c0 = cyc;
      send(7, 3, 5);
      wait_valid("t1_seen", vc);
      chk("t1_latency", 32'(vc - c0), 32'd8);
      drain("t1_drain");
      chk("t1_count", 32'(obs_log.size()), 32'd1);
      chk("t1_addr", 32'(obs_log[0].addr), 32'd0);
      chk("t1_mask", 32'(obs_log[0].mask), 32'h0018);
      chk("t1_last", 32'(obs_log[0].last), 32'd1);
      chk("t1_vid",  32'(obs_log[0].vid),  32'd7);

      // Case 2: three-line range
      obs_log.delete();
      send(9, 14, 35);
      drain("t2_drain");
      chk("t2_count", 32'(obs_log.size()), 32'd3);
      chk("t2_mask0", 32'(obs_log[0].mask), 32'hC000);
      chk("t2_mask1", 32'(obs_log[1].mask), 32'hFFFF);
      chk("t2_mask2", 32'(obs_log[2].mask), 32'h0007);
      chk("t2_addr2", 32'(obs_log[2].addr), 32'd2);
      chk("t2_last1", 32'(obs_log[1].last), 32'd0);
      chk("t2_last2", 32'(obs_log[2].last), 32'd1);

      // Case 3: zero-degree entry followed by a one-edge vertex
      obs_log.delete();
      send(20, 20, 20);
      send(21, 16, 17);
      drain("t3_drain");
      chk("t3_count", 32'(obs_log.size()), 32'd1);
      chk("t3_addr", 32'(obs_log[0].addr), 32'd1);
      chk("t3_mask", 32'(obs_log[0].mask), 32'h0001);
      chk("t3_vid",  32'(obs_log[0].vid),  32'd21);

      // Case 4: downstream full for 4 cycles mid-range
      obs_log.delete();
      send(9, 14, 35);
      wait_valid("t4_seen", vc);
      @(posedge clk); #1;
      edge_rd_full = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      edge_rd_full = 1'b0;
      drain("t4_drain");
      chk("t4_count", 32'(obs_log.size()), 32'd3);
      chk("t4_addr1", 32'(obs_log[1].addr), 32'd1);
      chk("t4_mask2", 32'(obs_log[2].mask), 32'h0007);

      // Case 5: front obeys stall while downstream is blocked
      obs_log.delete();
      edge_rd_full = 1'b1;
      nsent = 0;
      stall_at = -1;
      c0 = cyc;
      for (int i = 0; i < 40; i++) begin
         if (front_stall) begin
            front_valid = 1'b0;
            if (stall_at < 0) stall_at = cyc - c0;
         end else begin
            vid = 100 + nsent;
            l_tab[vid] = nsent * 16 + 1;
            r_tab[vid] = nsent * 16 + 4;
            expect_vertex(vid, l_tab[vid], r_tab[vid]);
            front_id    = VW'(vid);
            front_valid = 1'b1;
            nsent++;
         end
         @(posedge clk); #1;
      end
      front_valid = 1'b0;
      chk("t5_stall_cycle", 32'(stall_at), 32'd16);
      chk("t5_sent", 32'(nsent), 32'd16);
      chk("t5_stall_held", 32'(front_stall), 32'd1);
      chk("t5_ovf", 32'(err_overflow), 32'd0);
      edge_rd_full = 1'b0;
      drain("t5_drain");
      chk("t5_count", 32'(obs_log.size()), 32'd16);
      chk("t5_last_addr", 32'(obs_log[15].addr), 32'd15);

      // Overflow: front ignores stall, pushes beyond capacity
      ovf_watch = 1'b0;
      edge_rd_full = 1'b1;
      for (int i = 0; i < 24; i++) begin
         vid = 150 + i;
         l_tab[vid] = 0; r_tab[vid] = 2;
         front_id = VW'(vid);
         front_valid = 1'b1;
         @(posedge clk); #1;
      end
      front_valid = 1'b0;
      repeat (8) @(posedge clk);
      @(negedge clk);
      chk("ovf_set", 32'(err_overflow), 32'd1);
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("ovf_sticky", 32'(err_overflow), 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      edge_rd_full = 1'b0;
      @(negedge clk);
      chk_reset_outputs("ovf_reset");
      ovf_watch = 1'b1;
      @(posedge clk); #1;

      // Case 6: reset during ISSUE, then a fresh vertex
      obs_log.delete();
      send(9, 14, 35);
      wait_valid("t6_seen", vc);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk_reset_outputs("t6_reset");
      repeat (20) @(posedge clk);
      #1;
      obs_log.delete();
      send(7, 3, 5);
      drain("t6_drain");
      chk("t6_count", 32'(obs_log.size()), 32'd1);
      chk("t6_mask", 32'(obs_log[0].mask), 32'h0018);
      chk("t6_last", 32'(obs_log[0].last), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
